uart_program_loader: RTL and testbench

- CPU-side boot loader. Sits between the CPU's UART_RX/UART_TX byte ports and the instruction-memory write port.
- Boot sequence:
  - Announces readiness with byte 0x99.
  - Receives a 4-byte little-endian program size, then that many program bytes, packed into 32-bit words.
  - Writes the words into instruction memory.
  - Sends 0xAA and releases the core.
- After boot it hands the UART to the core untouched; stdin bytes then pass straight through.

---
 rtl/uart_loader_pkg.sv | 20 ++
 rtl/tx_byte_sender.sv | 40 ++++
 rtl/uart_program_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader.
//   state_e        : loader FSM states
//   READY_BYTE_DEF : default byte sent to request a program
//   ACK_BYTE_DEF   : default byte sent once the program is in imem
//   BYTES_PER_WORD : bytes packed into one imem word
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_SEND_READY,
    S_RECV_SIZE,
    S_RECV_DATA,
    S_SEND_ACK,
    S_DONE
  } state_e;

  localparam logic [7:0] READY_BYTE_DEF = 8'h99;
  localparam logic [7:0] ACK_BYTE_DEF   = 8'hAA;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/tx_byte_sender.sv
// Single-byte transmit handshake towards UART_TX.
//   clk, reset    : clock, synchronous active-high reset
//   req_i, data_i : caller wants data_i sent; held until accepted_o
//   tx_busy_i     : UART_TX busy
//   accepted_o    : combinational, high in the cycle the request is taken
//   tx_start_o    : one-cycle transmit pulse (registered)
//   tx_data_o     : byte presented with tx_start_o (registered)
module tx_byte_sender (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic [7:0] data_i,
  input  logic       tx_busy_i,
  output logic       accepted_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o
);

  logic       tx_start_q;
  logic [7:0] tx_data_q;

  // UART_TX raises busy one cycle after seeing tx_start, so the cycle in
  // which tx_start is high doubles as the guard cycle: no second request
  // may slip through before busy becomes visible.
  assign accepted_o = req_i && !tx_busy_i && !tx_start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= accepted_o;
      if (accepted_o) tx_data_q <= data_i;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader between the CPU UART byte ports and the imem write port.
// Sends READY_BYTE, receives a 4-byte little-endian size and that many
// program bytes, packs them into 32-bit words written to imem, then sends
// ACK_BYTE and raises boot_done. Afterwards it ignores the UART entirely.
//   clk, reset                  : clock, synchronous active-high reset
//   rx_data/rx_ready/rx_ferr    : received byte, valid pulse, framing error
//   tx_busy/tx_data/tx_start    : UART_TX handshake
//   imem_we/imem_addr/imem_wdata: instruction memory word write port
//   boot_done                   : core released (held in reset while 0)
//   load_err                    : sticky oversize / framing error flag
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int         IMEM_WORDS = 256,
  parameter int         ADDR_W     = $clog2(IMEM_WORDS),
  parameter logic [7:0] READY_BYTE = READY_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_ferr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_done,
  output logic              load_err
);

  localparam logic [31:0] IMEM_BYTES = 32'(BYTES_PER_WORD * IMEM_WORDS);

  state_e             state_q, state_d;
  logic [31:0]        size_q, size_d;
  logic [1:0]         size_idx_q, size_idx_d;
  logic [31:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]        word_buf_q, word_buf_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic               boot_done_q, boot_done_d;
  logic               load_err_q, load_err_d;

  logic               tx_req, tx_acc;
  logic [7:0]         tx_byte;
  logic [31:0]        size_new, wb;
  logic               last_byte;

  tx_byte_sender u_tx (
    .clk       (clk),
    .reset     (reset),
    .req_i     (tx_req),
    .data_i    (tx_byte),
    .tx_busy_i (tx_busy),
    .accepted_o(tx_acc),
    .tx_start_o(tx_start),
    .tx_data_o (tx_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SEND_READY;
      size_q       <= '0;
      size_idx_q   <= '0;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      boot_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      size_idx_q   <= size_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      boot_done_q  <= boot_done_d;
      load_err_q   <= load_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    size_idx_d   = size_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    boot_done_d  = boot_done_q;
    load_err_d   = load_err_q;
    tx_req       = 1'b0;
    tx_byte      = READY_BYTE;
    size_new     = size_q;
    wb           = word_buf_q;
    last_byte    = 1'b0;

    case (state_q)
      S_SEND_READY: begin
        tx_req = 1'b1;
        if (tx_acc) state_d = S_RECV_SIZE;
      end

      S_RECV_SIZE: begin
        if (rx_ready) begin
          size_new[{size_idx_q, 3'b000} +: 8] = rx_data;
          size_d     = size_new;
          size_idx_d = size_idx_q + 2'd1;
          if (rx_ferr) load_err_d = 1'b1;
          if (size_idx_q == 2'd3) begin
            if (size_new > IMEM_BYTES) load_err_d = 1'b1;
            if (size_new == 32'd0) begin
              state_d = S_SEND_ACK;
            end else begin
              state_d    = S_RECV_DATA;
              byte_cnt_d = '0;
              word_buf_d = '0;
            end
          end
        end
      end

      S_RECV_DATA: begin
        if (rx_ready) begin
          wb[{byte_cnt_q[1:0], 3'b000} +: 8] = rx_data;
          last_byte = (byte_cnt_q + 32'd1) == size_q;
          if (rx_ferr) load_err_d = 1'b1;
          if ((&byte_cnt_q[1:0]) || last_byte) begin
            // Words past the end of imem are dropped rather than wrapped.
            if (byte_cnt_q < IMEM_BYTES) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = byte_cnt_q[ADDR_W+1:2];
              imem_wdata_d = wb;
            end
            // Cleared so a trailing partial word has zero upper lanes.
            word_buf_d = '0;
          end else begin
            word_buf_d = wb;
          end
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (last_byte) state_d = S_SEND_ACK;
        end
      end

      S_SEND_ACK: begin
        tx_req  = 1'b1;
        tx_byte = ACK_BYTE;
        if (tx_acc) begin
          boot_done_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      default: ;  // S_DONE: UART belongs to the core now
    endcase
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign boot_done  = boot_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  localparam int IMEM_WORDS = 256;
  localparam int ADDR_W     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rx_ferr;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              boot_done;
  logic              load_err;

  always #5 clk = ~clk;

  uart_program_loader #(.IMEM_WORDS(IMEM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_ferr   (rx_ferr),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .boot_done (boot_done),
    .load_err  (load_err)
  );

  // UART_TX stand-in: busy rises one cycle after tx_start, lasts 4 cycles.
  int busy_cnt;
  always @(posedge clk) begin
    if (reset)              busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  int n_checks = 0;
  int n_pass   = 0;
  int tx_cnt   = 0;
  int wr_cnt   = 0;
  logic [7:0]  tx_q[$];
  logic [39:0] wr_q[$];
  logic [7:0]  prog[$];
  int          ferr_at = -1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: every tx_start and imem write pops an expectation.
  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt++;
      if (tx_q.size() == 0) check("tx_unexpected", 40'(tx_q.size()), 40'd1);
      else                  check("tx_byte", {32'b0, tx_data}, {32'b0, tx_q.pop_front()});
    end
    if (imem_we) begin
      wr_cnt++;
      if (wr_q.size() == 0) check("wr_unexpected", 40'(wr_q.size()), 40'd1);
      else                  check("imem_wr", {imem_addr, imem_wdata}, wr_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    @(posedge clk); #1;
    rx_data = b; rx_ready = 1'b1; rx_ferr = ferr;
    @(posedge clk); #1;
    rx_ready = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && tx_cnt < target; i++) @(posedge clk);
    check(tag, 40'(tx_cnt), 40'(target));
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_tx_data",    {32'b0, tx_data}, 40'h0);
    check("rst_tx_start",   {39'b0, tx_start}, 40'h0);
    check("rst_imem_we",    {39'b0, imem_we}, 40'h0);
    check("rst_imem_addr",  {32'b0, imem_addr}, 40'h0);
    check("rst_imem_wdata", {8'b0, imem_wdata}, 40'h0);
    check("rst_boot_done",  {39'b0, boot_done}, 40'h0);
    check("rst_load_err",   {39'b0, load_err}, 40'h0);
  endtask

  task automatic release_reset();
    int t;
    tx_q.push_back(8'h99);
    t = tx_cnt + 1;
    reset = 1'b0;
    wait_tx(t, 2, "ready_latency");
  endtask

  task automatic run_prog(input logic [31:0] size, input logic err_after_size,
                          input logic err_final);
    int t;
    int w0;
    w0 = wr_cnt;
    tx_q.push_back(8'hAA);
    for (int k = 0; k < 4; k++) send_byte(size[8*k +: 8], 1'b0);
    check("err_after_size", {39'b0, load_err}, {39'b0, err_after_size});
    check("boot_done_early", {39'b0, boot_done}, 40'h0);
    t = tx_cnt + 1;
    for (int i = 0; i < prog.size(); i++) send_byte(prog[i], i == ferr_at);
    wait_tx(t, 6, "ack_tx");
    check("boot_done", {39'b0, boot_done}, 40'h1);
    check("load_err_final", {39'b0, load_err}, {39'b0, err_final});
    check("writes_left", 40'(wr_q.size()), 40'd0);
    check("tx_left", 40'(tx_q.size()), 40'd0);
    $display("program size %0d loaded, %0d writes", size, wr_cnt - w0);
  endtask

  task automatic set_prog1();
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    ferr_at = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; rx_ferr = 1'b0;
    @(posedge clk); #1;
    do_reset();
    release_reset();

    // Two full words; then S_DONE must ignore further rx traffic.
    set_prog1();
    w0 = wr_cnt;
    wr_q.push_back({8'd0, 32'h0000_0013});
    wr_q.push_back({8'd1, 32'h0010_0093});
    run_prog(32'd8, 1'b0, 1'b0);
    check("prog1_writes", 40'(wr_cnt - w0), 40'd2);
    w0 = wr_cnt;
    send_byte(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("done_ignores_rx", 40'(wr_cnt - w0), 40'd0);
    check("done_stays", {39'b0, boot_done}, 40'h1);

    // Partial final word: upper lanes zero.
    do_reset();
    release_reset();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    ferr_at = -1;
    w0 = wr_cnt;
    wr_q.push_back({8'd0, 32'h0403_0201});
    wr_q.push_back({8'd1, 32'h0000_0605});
    run_prog(32'd6, 1'b0, 1'b0);
    check("prog6_writes", 40'(wr_cnt - w0), 40'd2);

    // Empty program: ACK straight after the size.
    do_reset();
    release_reset();
    prog.delete();
    ferr_at = -1;
    w0 = wr_cnt;
    run_prog(32'd0, 1'b0, 1'b0);
    check("prog0_writes", 40'(wr_cnt - w0), 40'd0);

    // Framing error mid-data: byte still used, load_err sticks.
    do_reset();
    release_reset();
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ferr_at = 1;
    w0 = wr_cnt;
    wr_q.push_back({8'd0, 32'hDDCC_BBAA});
    run_prog(32'd4, 1'b0, 1'b1);
    check("ferr_writes", 40'(wr_cnt - w0), 40'd1);

    // Oversize: 1032 bytes, only the first 256 words land in imem.
    do_reset();
    release_reset();
    prog.delete();
    ferr_at = -1;
    for (int i = 0; i < 1032; i++) prog.push_back(8'(i));
    for (int w = 0; w < IMEM_WORDS; w++)
      wr_q.push_back({8'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    w0 = wr_cnt;
    run_prog(32'h0000_0408, 1'b1, 1'b1);
    check("oversize_writes", 40'(wr_cnt - w0), 40'd256);

    // Reset in the middle of a load, then a clean reload.
    do_reset();
    release_reset();
    set_prog1();
    wr_q.push_back({8'd0, 32'h0000_0013});
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 8 : 0), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b0);
    check("partial_writes_left", 40'(wr_q.size()), 40'd0);
    do_reset();
    release_reset();
    w0 = wr_cnt;
    wr_q.push_back({8'd0, 32'h0000_0013});
    wr_q.push_back({8'd1, 32'h0010_0093});
    run_prog(32'd8, 1'b0, 1'b0);
    check("reload_writes", 40'(wr_cnt - w0), 40'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
